tx_lane_scheduler: RTL



---
 rtl/tx_lane_scheduler_pkg.sv | 9 +
 rtl/tx_lane_scheduler_rr_arbiter.sv | 30 +++
 rtl/tx_lane_scheduler.sv | 90 +++++++++
 3 files changed

// File: rtl/tx_lane_scheduler_pkg.sv
// phy_tx_pkg: shared symbols, scheduler states and header helper for the phy_tx lane scheduler.
package phy_tx_pkg;
   localparam logic [7:0] COM_SYMBOL = 8'hBC;
   localparam logic [7:0] HDR_TAG = 8'hF0;
   typedef enum logic [1:0] {INIT, IDLE, SEND, GAP} state_t;
   function automatic logic [7:0] hdr_byte(input logic [2:0] id, input logic [7:0] tag = HDR_TAG);
      return tag | {5'b0, id};
   endfunction
endpackage

// File: rtl/tx_lane_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick starting just above the last grant.
module rr_arbiter
   import phy_tx_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       last,
   output logic [N_REQ-1:0] grant,
   output logic [2:0]       id,
   output logic             any_req
);
   always_comb begin
      int idx;
      logic found;
      grant = '0;
      id = '0;
      found = 1'b0;
      idx = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last) + k) % N_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            grant[idx] = 1'b1;
            id = 3'(idx);
         end
      end
   end
   assign any_req = |req;
endmodule

// File: rtl/tx_lane_scheduler.sv
// tx_lane_scheduler: shares the serializer between requesters after the COM training period,
// granting round-robin bursts that each start with a channel-id header byte.
module tx_lane_scheduler
   import phy_tx_pkg::*;
#(
   parameter int         N_REQ     = 4,
   parameter int         INIT_IDLE = 16,
   parameter int         MAX_BURST = 8,
   parameter logic [7:0] HDR_TAG   = phy_tx_pkg::HDR_TAG
) (
   input  logic               clk_4f,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_ready,
   output logic               valid_out,
   output logic [7:0]         data_out,
   output logic [2:0]         grant_id,
   output logic               init_done
);
   localparam int IW = $clog2(INIT_IDLE + 1);
   state_t state;
   logic [IW-1:0] idle_cnt;
   logic [7:0] beat_cnt;
   logic [2:0] last_grant;
   logic [N_REQ-1:0] grant_oh;
   logic [N_REQ-1:0] pick_grant;
   logic [2:0] pick_id;
   logic any_req;
   logic [7:0] cur_byte;
   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req     (req_valid),
      .last    (last_grant),
      .grant   (pick_grant),
      .id      (pick_id),
      .any_req (any_req)
   );
   // Only the latched owner is served; reset cuts the handshake in the same cycle.
   assign req_ready = (state == SEND && !reset) ? (req_valid & grant_oh) : '0;
   assign cur_byte = req_data[int'(grant_id)*8 +: 8];
   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state <= INIT;
         idle_cnt <= '0;
         beat_cnt <= '0;
         last_grant <= 3'(N_REQ - 1);
         grant_oh <= '0;
         valid_out <= 1'b0;
         data_out <= '0;
         grant_id <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               valid_out <= 1'b0;
               idle_cnt <= idle_cnt + 1'b1;
               if (idle_cnt == IW'(INIT_IDLE - 1)) begin
                  init_done <= 1'b1;
                  state <= IDLE;
               end
            end
            IDLE: begin
               valid_out <= any_req;
               if (any_req) begin
                  grant_id <= pick_id;
                  last_grant <= pick_id;
                  grant_oh <= pick_grant;
                  data_out <= hdr_byte(pick_id, HDR_TAG);
                  beat_cnt <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               valid_out <= |req_ready;
               if (|req_ready) begin
                  data_out <= cur_byte;
                  beat_cnt <= beat_cnt + 8'd1;
                  if (beat_cnt + 8'd1 == 8'(MAX_BURST)) state <= GAP;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               valid_out <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
